shiftreg_serializer: RTL and testbench



---
 rtl/shiftreg_ser_pkg.sv | 33 +++
 rtl/shiftreg_baud_tick.sv | 51 +++++
 rtl/shiftreg_serializer.sv | 170 +++++++++++++++++
 tb/tb_shiftreg_serializer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shiftreg_ser_pkg.sv
// ============================================================================
// Module      : shiftreg_ser_pkg
// Description : Shared types and constants for the framed serial transmitter
//               that follows the 4-bit universal shift register.
//               Optional feature macro: SHIFTREG_SER_PARITY_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shiftreg_ser_pkg;

  // Transmitter FSM states; PARITY is only visited when parity is built in
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } ser_state_e;

  // Line levels of the frame
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shiftreg_baud_tick.sv
// ============================================================================
// Module      : shiftreg_baud_tick
// Description : Bit-period counter. Counts 0..BAUD_DIV-1 while the FSM is
//               out of IDLE and flags the last clock of every bit period.
//               Optional feature macro: none (used by SHIFTREG_SER_PARITY_EN
//               builds unchanged)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shiftreg_baud_tick
  import shiftreg_ser_pkg::*;
#(
  parameter int BAUD_DIV = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  output logic bit_tick_o
);

  localparam int               CNT_W = cnt_width(BAUD_DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Held at zero in IDLE so the first bit period starts from a clean count
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign bit_tick_o = !clr_i && (cnt_q == LAST);

  // Counter register, cleared asynchronously by reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/shiftreg_serializer.sv
// ============================================================================
// Module      : shiftreg_serializer
// Description : Accepts a parallel word over valid/ready and sends it as a
//               framed serial stream: start bit, WIDTH data bits, stop bit,
//               each bit held for BAUD_DIV clocks.
//               Optional feature macro: SHIFTREG_SER_PARITY_EN (adds an
//               even-parity bit between the data bits and the stop bit)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shiftreg_serializer
  import shiftreg_ser_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int BAUD_DIV  = 1,
  parameter int LSB_FIRST = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] DATAIN,
  input  logic             DATAIN_VALID,
  output logic             DATAIN_READY,
  output logic             SEROUT,
  output logic             BUSY,
  output logic             DONE
);

  localparam int               BIT_W    = cnt_width(WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0] bitcnt_q, bitcnt_d;
  logic             serout_q, serout_d;
  logic             busy_q;
  logic             ready_q;
`ifdef SHIFTREG_SER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic             w_bit_tick;
  logic             w_done;
  logic             w_first_bit;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_shifted;

  shiftreg_baud_tick #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_tick (
    .clock      (clock),
    .reset      (reset),
    .clr_i      (state_q == IDLE),
    .bit_tick_o (w_bit_tick)
  );

  // Bit order: the word always drains toward the end being transmitted
  generate
    if (LSB_FIRST != 0) begin : g_lsb_first
      assign w_first_bit = shreg_q[0];
      assign w_shifted   = shreg_q >> 1;
      assign w_next_bit  = w_shifted[0];
    end else begin : g_msb_first
      assign w_first_bit = shreg_q[WIDTH-1];
      assign w_shifted   = shreg_q << 1;
      assign w_next_bit  = w_shifted[WIDTH-1];
    end
  endgenerate

  // Next state; serout_d is the level the line will carry in that next state
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    serout_d = serout_q;
    w_done   = 1'b0;
`ifdef SHIFTREG_SER_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        serout_d = IDLE_LEVEL;
        if (DATAIN_VALID && ready_q) begin
          state_d  = START;
          shreg_d  = DATAIN;
          bitcnt_d = '0;
          serout_d = START_BIT;
`ifdef SHIFTREG_SER_PARITY_EN
          parity_d = ^DATAIN;
`endif
        end
      end
      START: begin
        if (w_bit_tick) begin
          state_d  = DATA;
          serout_d = w_first_bit;
        end
      end
      DATA: begin
        if (w_bit_tick) begin
          if (bitcnt_q == LAST_BIT) begin
`ifdef SHIFTREG_SER_PARITY_EN
            state_d  = PARITY;
            serout_d = parity_q;
`else
            state_d  = STOP;
            serout_d = STOP_BIT;
`endif
          end else begin
            shreg_d  = w_shifted;
            bitcnt_d = bitcnt_q + BIT_W'(1);
            serout_d = w_next_bit;
          end
        end
      end
`ifdef SHIFTREG_SER_PARITY_EN
      PARITY: begin
        if (w_bit_tick) begin
          state_d  = STOP;
          serout_d = STOP_BIT;
        end
      end
`endif
      STOP: begin
        if (w_bit_tick) begin
          state_d  = IDLE;
          serout_d = IDLE_LEVEL;
          w_done   = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        serout_d = IDLE_LEVEL;
      end
    endcase
  end

  // State, datapath and registered outputs; reset aborts any frame at once
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      serout_q <= IDLE_LEVEL;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
`ifdef SHIFTREG_SER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      serout_q <= serout_d;
      busy_q   <= (state_d != IDLE);
      ready_q  <= (state_d == IDLE);
`ifdef SHIFTREG_SER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign DATAIN_READY = ready_q;
  assign SEROUT       = serout_q;
  assign BUSY         = busy_q;
  assign DONE         = w_done;

endmodule

`default_nettype wire

// File: tb/tb_shiftreg_serializer.sv
// ============================================================================
// Module      : tb_shiftreg_serializer
// Description : Self-checking bench for shiftreg_serializer. Two instances:
//               fast LSB-first (BAUD_DIV=1) and slow MSB-first (BAUD_DIV=3).
//               Honours SHIFTREG_SER_PARITY_EN in its reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shiftreg_serializer;

  localparam int W = 4;
`ifdef SHIFTREG_SER_PARITY_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] din   [2];
  logic         valid [2];
  logic         ready [2];
  logic         serout[2];
  logic         busy  [2];
  logic         done  [2];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int hs_cyc[$];
  int done_cnt[2] = '{0, 0};

  bit   exp_q[$];
  logic obs_ser[$], obs_busy[$], obs_done[$], obs_rdy[$];

  always #5 clock = ~clock;

  shiftreg_serializer #(.WIDTH(W), .BAUD_DIV(1), .LSB_FIRST(1)) u_fast (
    .clock(clock), .reset(reset), .DATAIN(din[0]), .DATAIN_VALID(valid[0]),
    .DATAIN_READY(ready[0]), .SEROUT(serout[0]), .BUSY(busy[0]), .DONE(done[0]));

  shiftreg_serializer #(.WIDTH(W), .BAUD_DIV(3), .LSB_FIRST(0)) u_slow (
    .clock(clock), .reset(reset), .DATAIN(din[1]), .DATAIN_VALID(valid[1]),
    .DATAIN_READY(ready[1]), .SEROUT(serout[1]), .BUSY(busy[1]), .DONE(done[1]));

  // Handshake log for the fast instance and DONE pulse counters
  always @(posedge clock) begin
    if (valid[0] === 1'b1 && ready[0] === 1'b1) hs_cyc.push_back(cyc);
    cyc = cyc + 1;
  end

  always @(negedge clock) begin
    if (done[0] === 1'b1) done_cnt[0]++;
    if (done[1] === 1'b1) done_cnt[1]++;
  end

  function automatic int bd_of(input int idx);
    return (idx == 0) ? 1 : 3;
  endfunction

  function automatic int frame_len(input int idx);
    return (W + 2 + EXTRA) * bd_of(idx);
  endfunction

  // Reference frame: list of line levels, one per clock after acceptance
  function automatic void model_frame(input int idx, input logic [W-1:0] d);
    int bd;
    bit lsb;
    bd  = bd_of(idx);
    lsb = (idx == 0);
    exp_q.delete();
    repeat (bd) exp_q.push_back(1'b0);
    for (int k = 0; k < W; k++) begin
      bit v;
      v = lsb ? d[k] : d[W-1-k];
      repeat (bd) exp_q.push_back(v);
    end
`ifdef SHIFTREG_SER_PARITY_EN
    begin
      bit p;
      p = ($countones(d) % 2) == 1;
      repeat (bd) exp_q.push_back(p);
    end
`endif
    repeat (bd) exp_q.push_back(1'b1);
  endfunction

  // Present a word from a negedge and return just after the accepting edge
  task automatic handshake(input int idx, input logic [W-1:0] d, output bit ok);
    int t;
    din[idx]   = d;
    valid[idx] = 1'b1;
    ok = 1'b1;
    t  = 0;
    while (ready[idx] !== 1'b1) begin
      @(negedge clock);
      t++;
      if (t > 200) begin
        n_checks++;
        $display("FAIL handshake_timeout idx=%0d ready=%b required=1", idx, ready[idx]);
        ok = 1'b0;
        break;
      end
    end
    @(posedge clock);
    #1;
  endtask

  // Record n cycles of outputs, sampled at negedges
  task automatic capture(input int idx, input int n);
    obs_ser.delete(); obs_busy.delete(); obs_done.delete(); obs_rdy.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      obs_ser.push_back(serout[idx]);
      obs_busy.push_back(busy[idx]);
      obs_done.push_back(done[idx]);
      obs_rdy.push_back(ready[idx]);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (serout[i] !== 1'b1 || ready[i] !== 1'b0 || busy[i] !== 1'b0 || done[i] !== 1'b0)
        $display("FAIL reset_values idx=%0d ser=%b rdy=%b busy=%b done=%b required 1 0 0 0",
                 i, serout[i], ready[i], busy[i], done[i]);
      else n_pass++;
    end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    n_checks++;
    if (ready[0] !== 1'b0) $display("FAIL ready_before_edge ready=%b required=0", ready[0]);
    else n_pass++;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (ready[i] !== 1'b1 || serout[i] !== 1'b1 || busy[i] !== 1'b0)
        $display("FAIL ready_after_reset idx=%0d rdy=%b ser=%b busy=%b required 1 1 0",
                 i, ready[i], serout[i], busy[i]);
      else n_pass++;
    end
  endtask

  task automatic test_basic_lsb();
    logic [W-1:0] words[2] = '{4'b1011, 4'b0111};
    bit ok;
    int n;
    for (int w = 0; w < 2; w++) begin
      handshake(0, words[w], ok);
      valid[0] = 1'b0;
      model_frame(0, words[w]);
      n = exp_q.size();
      capture(0, n + 1);
      for (int i = 0; i < n; i++) begin
        n_checks++;
        if (obs_ser[i] !== exp_q[i] || obs_busy[i] !== 1'b1 || obs_done[i] !== (i == n - 1))
          $display("FAIL basic_lsb word=%b cyc=%0d ser=%b busy=%b done=%b required ser=%b busy=1 done=%b",
                   words[w], i + 1, obs_ser[i], obs_busy[i], obs_done[i], exp_q[i], (i == n - 1));
        else n_pass++;
      end
      n_checks++;
      if (obs_ser[n] !== 1'b1 || obs_busy[n] !== 1'b0 || obs_done[n] !== 1'b0 || obs_rdy[n] !== 1'b1)
        $display("FAIL basic_lsb_idle ser=%b busy=%b done=%b rdy=%b required 1 0 0 1",
                 obs_ser[n], obs_busy[n], obs_done[n], obs_rdy[n]);
      else n_pass++;
    end
  endtask

  task automatic test_msb_slow();
    bit ok;
    int n;
    handshake(1, 4'b1000, ok);
    valid[1] = 1'b0;
    model_frame(1, 4'b1000);
    n = exp_q.size();
    n_checks++;
    if (n !== frame_len(1)) $display("FAIL msb_slow_len model=%0d required=%0d", n, frame_len(1));
    else n_pass++;
    capture(1, n + 1);
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (obs_ser[i] !== exp_q[i] || obs_busy[i] !== 1'b1 || obs_done[i] !== (i == n - 1))
        $display("FAIL msb_slow cyc=%0d ser=%b busy=%b done=%b required ser=%b busy=1 done=%b",
                 i + 1, obs_ser[i], obs_busy[i], obs_done[i], exp_q[i], (i == n - 1));
      else n_pass++;
    end
    n_checks++;
    if (obs_rdy[n] !== 1'b1 || obs_done[n] !== 1'b0 || obs_busy[n] !== 1'b0)
      $display("FAIL msb_slow_idle rdy=%b done=%b busy=%b required 1 0 0", obs_rdy[n], obs_done[n], obs_busy[n]);
    else n_pass++;
  endtask

  task automatic test_random();
    bit ok;
    int n;
    logic [W-1:0] d;
    for (int r = 0; r < 10; r++) begin
      int idx;
      idx = r % 2;
      d = W'($urandom_range(0, (1 << W) - 1));
      handshake(idx, d, ok);
      valid[idx] = 1'b0;
      model_frame(idx, d);
      n = exp_q.size();
      capture(idx, n);
      for (int i = 0; i < n; i++) begin
        n_checks++;
        if (obs_ser[i] !== exp_q[i] || obs_done[i] !== (i == n - 1))
          $display("FAIL random idx=%0d word=%h cyc=%0d ser=%b done=%b required ser=%b done=%b",
                   idx, d, i + 1, obs_ser[i], obs_done[i], exp_q[i], (i == n - 1));
        else n_pass++;
      end
    end
    repeat (2) @(negedge clock);
  endtask

  // Two words with VALID held high; the second must follow in the single IDLE cycle
  task automatic run_pair(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    bit ok;
    int n;
    logic [W-1:0] words[2];
    words[0] = a;
    words[1] = b;
    hs_cyc.delete();
    handshake(0, a, ok);
    din[0] = b;
    for (int w = 0; w < 2; w++) begin
      if (w == 1) begin
        @(posedge clock);
        #1 valid[0] = 1'b0;
      end
      model_frame(0, words[w]);
      n = exp_q.size();
      capture(0, n + 1);
      for (int i = 0; i < n; i++) begin
        n_checks++;
        if (obs_ser[i] !== exp_q[i] || obs_busy[i] !== 1'b1 || obs_done[i] !== (i == n - 1))
          $display("FAIL %s word=%h cyc=%0d ser=%b busy=%b done=%b required ser=%b busy=1 done=%b",
                   tag, words[w], i + 1, obs_ser[i], obs_busy[i], obs_done[i], exp_q[i], (i == n - 1));
        else n_pass++;
      end
      n_checks++;
      if (obs_ser[n] !== 1'b1 || obs_busy[n] !== 1'b0 || obs_rdy[n] !== 1'b1)
        $display("FAIL %s_idle ser=%b busy=%b rdy=%b required 1 0 1", tag, obs_ser[n], obs_busy[n], obs_rdy[n]);
      else n_pass++;
    end
    n_checks++;
    if (hs_cyc.size() !== 2 || (hs_cyc[1] - hs_cyc[0]) !== frame_len(0) + 1)
      $display("FAIL %s_spacing count=%0d gap=%0d required count=2 gap=%0d", tag, hs_cyc.size(),
               (hs_cyc.size() >= 2) ? hs_cyc[1] - hs_cyc[0] : -1, frame_len(0) + 1);
    else n_pass++;
  endtask

  task automatic test_busy_reject();
    run_pair(4'hA, 4'h5, "busy_reject");
  endtask

  task automatic test_back_to_back();
    run_pair(4'h1, 4'hF, "back_to_back");
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    int dc;
    handshake(0, 4'hC, ok);
    valid[0] = 1'b0;
    dc = done_cnt[0];
    repeat (4) @(negedge clock);
    reset = 1'b0;
    #1;
    n_checks++;
    if (serout[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0 || ready[0] !== 1'b0)
      $display("FAIL reset_mid ser=%b busy=%b done=%b rdy=%b required 1 0 0 0",
               serout[0], busy[0], done[0], ready[0]);
    else n_pass++;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (8) @(negedge clock);
    n_checks++;
    if (done_cnt[0] !== dc) $display("FAIL reset_mid_done pulses=%0d required=0", done_cnt[0] - dc);
    else n_pass++;
    handshake(0, 4'h3, ok);
    valid[0] = 1'b0;
    model_frame(0, 4'h3);
    n = exp_q.size();
    capture(0, n);
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (obs_ser[i] !== exp_q[i] || obs_done[i] !== (i == n - 1))
        $display("FAIL reset_mid_frame cyc=%0d ser=%b done=%b required ser=%b done=%b",
                 i + 1, obs_ser[i], obs_done[i], exp_q[i], (i == n - 1));
      else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      din[i]   = '0;
      valid[i] = 1'b0;
    end
    test_reset();
    test_basic_lsb();
    test_msb_slow();
    test_random();
    test_busy_reject();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish, passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule

`default_nettype wire
